div_seq: RTL and testbench

Parametrised sequential divider: a WIDTH-bit restoring divider with an integrated controller and an internal iteration counter, so no external terminal-count input is needed. It adds signed mode, divide-by-zero detection, a busy flag and synchronous abort. It sits beside the ALU and is driven by a start/done level handshake, taking new work directly from DONE.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_seq_ctrl.sv | 64 ++++++
 rtl/div_seq.sv | 106 ++++++++++
 tb/tb_div_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counter must hold the value WIDTH, hence the +1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_seq_ctrl.sv
// Controller for div_seq: state sequencing and the SHIFT iteration counter.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic divisor_zero,
    output logic load,
    output logic shift,
    output logic fix,
    output logic done
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = LOAD;
                LOAD:    state_next = divisor_zero ? DONE : SHIFT;
                SHIFT:   if (cnt == LAST) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    if (start) state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            load  <= 1'b0;
            shift <= 1'b0;
            fix   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == SHIFT) begin
                cnt <= cnt + CNT_W'(1);
            end
            load  <= (state_next == LOAD);
            shift <= (state_next == SHIFT);
            fix   <= (state_next == FIX);
            done  <= (state_next == DONE);
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider with signed mode, divide-by-zero flag and abort.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             dbz
);

    logic             load;
    logic             shift;
    logic             fix;
    logic             accept;
    logic             divisor_zero;

    logic             sgn;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   pr;
    logic [WIDTH-1:0] qw;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    div_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .divisor_zero (divisor_zero),
        .load         (load),
        .shift        (shift),
        .fix          (fix),
        .done         (done)
    );

    assign busy         = load | shift | fix;
    assign accept       = start & ~abort & ~busy;
    assign divisor_zero = (divisor == '0);

    assign dvd_abs = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_abs = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One extra guard bit on the trial keeps its sign valid for any unsigned divisor.
    assign shifted = {pr[WIDTH-1:0], qw[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b0, dvs_mag};

    assign q_fix = (sgn && (dvd_neg ^ dvs_neg)) ? -qw : qw;
    assign r_fix = (sgn && dvd_neg) ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn       <= 1'b0;
            dvd_neg   <= 1'b0;
            dvs_neg   <= 1'b0;
            dvs_mag   <= '0;
            pr        <= '0;
            qw        <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            if (accept) begin
                sgn <= signed_mode;
                dbz <= 1'b0;
            end
            if (load && !abort) begin
                dvd_neg <= sgn & dividend[WIDTH-1];
                dvs_neg <= sgn & divisor[WIDTH-1];
                dvs_mag <= dvs_abs;
                qw      <= dvd_abs;
                pr      <= '0;
                if (divisor_zero) begin
                    quotient  <= '1;
                    remainder <= dividend;
                    dbz       <= 1'b1;
                end
            end
            if (shift) begin
                qw <= {qw[WIDTH-2:0], ~trial[WIDTH+1]};
                pr <= trial[WIDTH+1] ? shifted : trial[WIDTH:0];
            end
            if (fix && !abort) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq (WIDTH=8): results, latency, handshake, abort and reset.
module tb_div_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       signed_mode;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       done;
    logic       busy;
    logic       dbz;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         n_checks;
    int         n_fail;
    logic [7:0] last_q;
    logic [7:0] last_r;

    div_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .dbz         (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic ed,
                            input int lat);
        exp_t e;
        e.q = eq; e.r = er; e.dbz = ed; e.lat = lat;
        sb.push_back(e);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; signed_mode = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        n_checks++;
        if ({quotient, remainder, done, busy, dbz} !== 19'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got q=%h r=%h done=%b busy=%b dbz=%b, expected all zero",
                     quotient, remainder, done, busy, dbz);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        exp_t e;
        int   c;
        int   bad;
        start_op(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 10);
        bad = (busy !== 1'b1) ? 1 : 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL unsigned_busy_window: got %0d bad cycles, expected 0", bad);
        end
        wait_done(c);
        e = sb.pop_front();
        n_checks++;
        if (c + 9 != e.lat) begin n_fail++; $display("[TB] FAIL unsigned_latency: got %0d expected %0d", c + 9, e.lat); end
        n_checks++;
        if (quotient !== e.q) begin n_fail++; $display("[TB] FAIL unsigned_q: got %h expected %h", quotient, e.q); end
        n_checks++;
        if (remainder !== e.r) begin n_fail++; $display("[TB] FAIL unsigned_r: got %h expected %h", remainder, e.r); end
        n_checks++;
        if (dbz !== e.dbz || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL unsigned_flags: got dbz=%b busy=%b expected dbz=%b busy=0", dbz, busy, e.dbz);
        end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_signed();
        logic [7:0] ta[4] = '{8'hF9, 8'h07, 8'h80, 8'h9C};
        logic [7:0] tb[4] = '{8'h02, 8'hFE, 8'hFF, 8'hF9};
        logic [7:0] tq[4] = '{8'hFD, 8'hFD, 8'h80, 8'h0E};
        logic [7:0] tr[4] = '{8'hFF, 8'h01, 8'h00, 8'hFE};
        exp_t e;
        int   c;
        for (int i = 0; i < 4; i++) begin
            start_op(1'b1, ta[i], tb[i], tq[i], tr[i], 1'b0, 10);
            wait_done(c);
            e = sb.pop_front();
            n_checks++;
            if (done !== 1'b1 || c != e.lat) begin
                n_fail++; $display("[TB] FAIL signed_latency[%0d]: got done=%b after %0d, expected %0d", i, done, c, e.lat);
            end
            n_checks++;
            if (quotient !== e.q) begin n_fail++; $display("[TB] FAIL signed_q[%0d]: got %h expected %h", i, quotient, e.q); end
            n_checks++;
            if (remainder !== e.r) begin n_fail++; $display("[TB] FAIL signed_r[%0d]: got %h expected %h", i, remainder, e.r); end
            last_q = e.q; last_r = e.r;
        end
    endtask

    task automatic test_dbz();
        exp_t e;
        int   c;
        start_op(1'b0, 8'd55, 8'd0, 8'hFF, 8'h37, 1'b1, 1);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL dbz_load: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        wait_done(c);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || c != e.lat) begin n_fail++; $display("[TB] FAIL dbz_latency: got %0d expected %0d", c, e.lat); end
        n_checks++;
        if (quotient !== e.q || remainder !== e.r) begin
            n_fail++; $display("[TB] FAIL dbz_result: got q=%h r=%h expected q=%h r=%h", quotient, remainder, e.q, e.r);
        end
        n_checks++;
        if (dbz !== e.dbz) begin n_fail++; $display("[TB] FAIL dbz_flag: got %b expected %b", dbz, e.dbz); end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_dbz_clear();
        exp_t e;
        int   c;
        start_op(1'b0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 10);
        n_checks++;
        if (dbz !== 1'b0) begin n_fail++; $display("[TB] FAIL dbz_clear_on_load: got %b expected 0", dbz); end
        wait_done(c);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || quotient !== e.q || remainder !== e.r || dbz !== e.dbz) begin
            n_fail++; $display("[TB] FAIL dbz_clear_result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                               quotient, remainder, dbz, e.q, e.r, e.dbz);
        end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   c;
        start_op(1'b0, 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 10);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; dividend = 8'd1; divisor = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(c);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || c + 4 != e.lat) begin
            n_fail++; $display("[TB] FAIL ignore_start_latency: got %0d expected %0d", c + 4, e.lat);
        end
        n_checks++;
        if (quotient !== e.q || remainder !== e.r) begin
            n_fail++; $display("[TB] FAIL ignore_start_result: got q=%h r=%h expected q=%h r=%h", quotient, remainder, e.q, e.r);
        end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c;
        start_op(1'b0, 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 10);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL b2b_reload: got done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        wait_done(c);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || c != e.lat) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", c, e.lat); end
        n_checks++;
        if (quotient !== e.q || remainder !== e.r) begin
            n_fail++; $display("[TB] FAIL b2b_result: got q=%h r=%h expected q=%h r=%h", quotient, remainder, e.q, e.r);
        end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_abort();
        signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_state: got done=%b busy=%b expected 0 0", done, busy);
        end
        n_checks++;
        if (quotient !== last_q || remainder !== last_r) begin
            n_fail++; $display("[TB] FAIL abort_hold: got q=%h r=%h expected q=%h r=%h", quotient, remainder, last_q, last_r);
        end
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_priority: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({quotient, remainder, done, busy, dbz} !== 19'b0) begin
            n_fail++; $display("[TB] FAIL reset_mid: got q=%h r=%h done=%b busy=%b dbz=%b expected all zero",
                               quotient, remainder, done, busy, dbz);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_after_reset();
        exp_t e;
        int   c;
        start_op(1'b0, 8'd15, 8'd4, 8'd3, 8'd3, 1'b0, 10);
        wait_done(c);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || c != e.lat) begin n_fail++; $display("[TB] FAIL post_reset_latency: got %0d expected %0d", c, e.lat); end
        n_checks++;
        if (quotient !== e.q || remainder !== e.r || dbz !== e.dbz) begin
            n_fail++; $display("[TB] FAIL post_reset_result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                               quotient, remainder, dbz, e.q, e.r, e.dbz);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_q   = '0;
        last_r   = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_dbz();
        test_dbz_clear();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
